// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache between the IF stage and the memory controller.
// One 32-bit word per line, single-cycle hit, miss filled from the controller's pc return path.
module icache_fetch #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        req_i,
    input  logic [31:0] pc_i,
    input  logic        cancel_i,
    input  logic        flush_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        busy_o,
    output logic [31:0] mem_pc_o,
    input  logic        mem_pc_done_i,
    input  logic [31:0] mem_pc_num_i,
    input  logic [31:0] mem_inst_i
);
    // state | meaning
    // IDLE  | lookup each cycle, serve hits, mem_pc_o tracks pc_i
    // MISS  | waiting for the controller to return the word at miss_addr

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {IDLE, MISS} state_t;
    state_t state, state_nxt;

    logic [LINES-1:0] valid_bits;
    logic [TAG_W-1:0] tag_ram  [LINES];
    logic [31:0]      data_ram [LINES];
    logic [31:0]      miss_addr;
    logic             pulse_q;

    logic [INDEX_W-1:0] pc_index;
    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   pc_tag;
    logic [TAG_W-1:0]   miss_tag;
    logic               pc_io;
    logic               miss_io;
    logic               hit;
    logic               fill_match;
    logic               start_miss;
    logic               hit_pulse;
    logic               fill_done;
    logic               fill_we;

    assign pc_index   = pc_i[INDEX_W+1:2];
    assign pc_tag     = pc_i[ADDR_W-1:INDEX_W+2];
    assign miss_index = miss_addr[INDEX_W+1:2];
    assign miss_tag   = miss_addr[ADDR_W-1:INDEX_W+2];
    assign pc_io      = (pc_i[ADDR_W-1:ADDR_W-2] == 2'b11);
    assign miss_io    = (miss_addr[ADDR_W-1:ADDR_W-2] == 2'b11);
    assign hit        = valid_bits[pc_index] && (tag_ram[pc_index] == pc_tag) && !pc_io;
    // Only the return for the missed PC completes the miss; speculative returns are dropped.
    assign fill_match = mem_pc_done_i && (mem_pc_num_i == miss_addr);

    // A pulse held across a rdy_in stall is suppressed until the block runs again.
    assign inst_valid_o = pulse_q & rdy_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_miss = 1'b0;
        hit_pulse  = 1'b0;
        fill_done  = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req_i && !cancel_i) begin
                    if (hit) begin
                        hit_pulse = 1'b1;
                    end else begin
                        start_miss = 1'b1;
                        state_nxt  = MISS;
                    end
                end
            end
            MISS: begin
                if (cancel_i) begin
                    state_nxt = IDLE;
                end else if (fill_match) begin
                    fill_done = 1'b1;
                    fill_we   = !miss_io;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt  = IDLE;
            start_miss = 1'b0;
            hit_pulse  = 1'b0;
            fill_done  = 1'b0;
            fill_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_q    <= 1'b0;
            inst_o     <= 32'h0;
            inst_pc_o  <= 32'h0;
            busy_o     <= 1'b0;
            mem_pc_o   <= 32'h0;
            miss_addr  <= 32'h0;
            valid_bits <= '0;
        end else if (rdy_in) begin
            pulse_q <= hit_pulse | fill_done;
            if (hit_pulse) begin
                inst_o    <= data_ram[pc_index];
                inst_pc_o <= pc_i;
            end else if (fill_done) begin
                inst_o    <= mem_inst_i;
                inst_pc_o <= miss_addr;
            end
            if (start_miss) begin
                miss_addr <= pc_i;
            end
            busy_o <= (state_nxt == MISS);
            // Held at miss_addr only while the miss stays outstanding.
            if (state == IDLE || state_nxt == IDLE) begin
                mem_pc_o <= pc_i;
            end
            if (flush_i) begin
                valid_bits <= '0;
            end else if (fill_we) begin
                valid_bits[miss_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy_in && fill_we) begin
            data_ram[miss_index] <= mem_inst_i;
            tag_ram[miss_index]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: inputs driven and outputs checked on the falling edge.
module tb_icache_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic        req_i;
    logic [31:0] pc_i;
    logic        cancel_i;
    logic        flush_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        busy_o;
    logic [31:0] mem_pc_o;
    logic        mem_pc_done_i;
    logic [31:0] mem_pc_num_i;
    logic [31:0] mem_inst_i;

    int errors = 0;
    int checks = 0;

    icache_fetch #(.INDEX_W(6), .ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .req_i(req_i), .pc_i(pc_i),
        .cancel_i(cancel_i), .flush_i(flush_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .busy_o(busy_o), .mem_pc_o(mem_pc_o),
        .mem_pc_done_i(mem_pc_done_i), .mem_pc_num_i(mem_pc_num_i), .mem_inst_i(mem_inst_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        req_i         = 1'b0;
        mem_pc_done_i = 1'b0;
        cancel_i      = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic do_miss(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        req_i = 1'b1;
        pc_i  = pc;
        tick();
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
        chk({tag, "_mempc"}, mem_pc_o, pc);
        chk({tag, "_nopulse"}, {31'h0, inst_valid_o}, 32'h0);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = pc;
        mem_inst_i    = inst;
        tick();
        chk({tag, "_fvalid"}, {31'h0, inst_valid_o}, 32'h1);
        chk({tag, "_finst"}, inst_o, inst);
        chk({tag, "_fpc"}, inst_pc_o, pc);
        chk({tag, "_fbusy"}, {31'h0, busy_o}, 32'h0);
        quiet();
        tick();
        chk({tag, "_single"}, {31'h0, inst_valid_o}, 32'h0);
    endtask

    task automatic do_hit(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        req_i = 1'b1;
        pc_i  = pc;
        tick();
        chk({tag, "_hvalid"}, {31'h0, inst_valid_o}, 32'h1);
        chk({tag, "_hinst"}, inst_o, inst);
        chk({tag, "_hpc"}, inst_pc_o, pc);
        chk({tag, "_hbusy"}, {31'h0, busy_o}, 32'h0);
        quiet();
        tick();
        chk({tag, "_hsingle"}, {31'h0, inst_valid_o}, 32'h0);
    endtask

    // Issue a request expected to miss and check the miss is raised, then leave it outstanding.
    task automatic expect_miss(input string tag, input logic [31:0] pc);
        req_i = 1'b1;
        pc_i  = pc;
        tick();
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
        chk({tag, "_mempc"}, mem_pc_o, pc);
        chk({tag, "_nopulse"}, {31'h0, inst_valid_o}, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        rdy_in = 1'b1;
        pc_i = 32'h0;
        mem_pc_num_i = 32'h0;
        mem_inst_i = 32'h0;
        quiet();
        tick();
        chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", inst_pc_o, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_mempc", mem_pc_o, 32'h0);
        rst = 1'b1;
        tick();

        // Cold miss then hit
        do_miss("cold", 32'h0000_1000, 32'h0050_0093);
        do_hit("rehit", 32'h0000_1000, 32'h0050_0093);

        // Stale return filter
        expect_miss("stale", 32'h0000_1004);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0000_1000;
        mem_inst_i    = 32'hdead_beef;
        tick();
        chk("stale_nopulse", {31'h0, inst_valid_o}, 32'h0);
        chk("stale_busy", {31'h0, busy_o}, 32'h1);
        chk("stale_mempc", mem_pc_o, 32'h0000_1004);
        mem_pc_num_i = 32'h0000_1004;
        mem_inst_i   = 32'h0000_0013;
        tick();
        chk("stale_fvalid", {31'h0, inst_valid_o}, 32'h1);
        chk("stale_finst", inst_o, 32'h0000_0013);
        chk("stale_fpc", inst_pc_o, 32'h0000_1004);
        quiet();
        tick();
        do_hit("stale_hit", 32'h0000_1004, 32'h0000_0013);
        do_hit("idx0_hit", 32'h0000_1000, 32'h0050_0093);

        // rdy_in low gates the pulse and freezes the block
        req_i = 1'b1;
        pc_i  = 32'h0000_1004;
        tick();
        chk("rdy_pre", {31'h0, inst_valid_o}, 32'h1);
        rdy_in = 1'b0;
        #1;
        chk("rdy_gate", {31'h0, inst_valid_o}, 32'h0);
        req_i = 1'b0;
        tick();
        chk("rdy_frozen", {31'h0, inst_valid_o}, 32'h0);
        rdy_in = 1'b1;
        #1;
        chk("rdy_resume", {31'h0, inst_valid_o}, 32'h1);
        chk("rdy_inst", inst_o, 32'h0000_0013);
        tick();
        chk("rdy_after", {31'h0, inst_valid_o}, 32'h0);

        // Conflict eviction on index 0
        do_miss("ev100", 32'h0000_0100, 32'h1111_1111);
        do_miss("ev200", 32'h0000_0200, 32'h2222_2222);
        do_hit("ev200h", 32'h0000_0200, 32'h2222_2222);
        expect_miss("ev100again", 32'h0000_0100);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0000_0100;
        mem_inst_i    = 32'h1111_1111;
        tick();
        chk("ev100_fvalid", {31'h0, inst_valid_o}, 32'h1);
        quiet();
        tick();
        expect_miss("ev1000", 32'h0000_1000);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0000_1000;
        mem_inst_i    = 32'h0050_0093;
        tick();
        quiet();
        tick();

        // IO addresses are never cached
        do_miss("io1", 32'h0003_0000, 32'haaaa_5555);
        expect_miss("io2", 32'h0003_0000);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0003_0000;
        mem_inst_i    = 32'haaaa_5555;
        tick();
        chk("io2_fvalid", {31'h0, inst_valid_o}, 32'h1);
        chk("io2_finst", inst_o, 32'haaaa_5555);
        quiet();
        tick();
        do_hit("io_noalias", 32'h0000_1000, 32'h0050_0093);

        // Cancel beats a matching fill
        expect_miss("cancel", 32'h0000_2008);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0000_2008;
        mem_inst_i    = 32'h0000_0055;
        cancel_i      = 1'b1;
        tick();
        chk("cancel_nopulse", {31'h0, inst_valid_o}, 32'h0);
        chk("cancel_busy", {31'h0, busy_o}, 32'h0);
        quiet();
        expect_miss("cancel_again", 32'h0000_2008);
        mem_pc_done_i = 1'b1;
        tick();
        chk("cancel_fill", {31'h0, inst_valid_o}, 32'h1);
        chk("cancel_finst", inst_o, 32'h0000_0055);
        quiet();
        tick();
        do_hit("cancel_hit", 32'h0000_2008, 32'h0000_0055);

        // Cancel in IDLE suppresses a hit
        req_i    = 1'b1;
        pc_i     = 32'h0000_2008;
        cancel_i = 1'b1;
        tick();
        chk("cancel_idle", {31'h0, inst_valid_o}, 32'h0);
        quiet();
        tick();

        // Flush invalidates and overrides a simultaneous fill
        do_hit("preflush", 32'h0000_1000, 32'h0050_0093);
        flush_i = 1'b1;
        tick();
        chk("flush_busy", {31'h0, busy_o}, 32'h0);
        chk("flush_valid", {31'h0, inst_valid_o}, 32'h0);
        flush_i = 1'b0;
        expect_miss("postflush", 32'h0000_1000);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0000_1000;
        mem_inst_i    = 32'h0050_0093;
        flush_i       = 1'b1;
        cancel_i      = 1'b1;
        tick();
        chk("flushfill_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("flushfill_busy", {31'h0, busy_o}, 32'h0);
        quiet();
        expect_miss("flushfill_nowrite", 32'h0000_1000);
        mem_pc_done_i = 1'b1;
        tick();
        chk("flushfill_fvalid", {31'h0, inst_valid_o}, 32'h1);
        quiet();
        tick();
        do_hit("refilled", 32'h0000_1000, 32'h0050_0093);

        // Async reset while a miss is outstanding
        expect_miss("arst", 32'h0000_300c);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'h0, busy_o}, 32'h0);
        chk("arst_mempc", mem_pc_o, 32'h0);
        chk("arst_inst", inst_o, 32'h0);
        chk("arst_pc", inst_pc_o, 32'h0);
        chk("arst_valid", {31'h0, inst_valid_o}, 32'h0);
        quiet();
        tick();
        rst = 1'b1;
        tick();
        expect_miss("arst_cold", 32'h0000_1000);
        mem_pc_done_i = 1'b1;
        mem_pc_num_i  = 32'h0000_1000;
        mem_inst_i    = 32'h0050_0093;
        tick();
        chk("arst_fvalid", {31'h0, inst_valid_o}, 32'h1);
        quiet();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller.
- Serves IF fetch requests from a tag/data array with single-cycle hit latency.
- On a miss, drives the miss PC onto the memory controller's pc input and waits for its pc_done/inst/pc_num return. It then fills the line and forwards the instruction.
- Replaces direct PC fetch through the memory controller.

Parameters:
- INDEX_W, 6, log2 of line count (64 lines, one 32-bit word per line)
- ADDR_W, 18, significant address bits; tag = pc[ADDR_W-1:INDEX_W+2]

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low freezes the block
- req_i  input  1  IF fetch request
- pc_i  input  32  fetch address; bits [1:0] ignored
- cancel_i  input  1  branch redirect; abandons outstanding fetch
- flush_i  input  1  invalidate all lines (fence.i)
- inst_valid_o  output  1  one-cycle pulse, inst_o/inst_pc_o valid
- inst_o  output  32  fetched instruction
- inst_pc_o  output  32  PC of inst_o
- busy_o  output  1  miss outstanding
- mem_pc_o  output  32  address to memory controller pc input
- mem_pc_done_i  input  1  memory controller instruction-return strobe
- mem_pc_num_i  input  32  PC the returned instruction belongs to
- mem_inst_i  input  32  returned instruction

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, all valid bits cleared.
  - inst_valid_o=0, inst_o=0, inst_pc_o=0, busy_o=0, mem_pc_o=0, miss_addr=0.
- States: IDLE, MISS.
- Lookup (combinational in IDLE):
  - index = pc_i[INDEX_W+1:2]; tag = pc_i[ADDR_W-1:INDEX_W+2].
  - hit = valid[index] && tag_ram[index]==tag && !io.
  - io = pc_i[17:16]==2'b11; IO addresses are never cached.
- IDLE:
  - mem_pc_o follows pc_i, registered one cycle. The resulting speculative fetch is harmless.
  - req_i && hit: next cycle inst_valid_o=1, inst_o=data_ram[index], inst_pc_o=pc_i. Stay in IDLE.
  - req_i && !hit: latch miss_addr=pc_i, mem_pc_o<=pc_i, busy_o<=1, go to MISS. inst_valid_o=0.
  - !req_i: inst_valid_o=0.
- MISS:
  - mem_pc_o held at miss_addr.
  - Fill accepted only when mem_pc_done_i && mem_pc_num_i==miss_addr. Returns for other PCs (stale speculative fetches) are ignored.
  - On accept:
    - If !io(miss_addr): write data_ram/tag_ram, set valid.
    - Next cycle: inst_valid_o=1, inst_o=mem_inst_i, inst_pc_o=miss_addr, busy_o=0, state=IDLE.
- Hit-to-valid latency 1 cycle. Miss latency = memory controller return + 1 cycle.
- inst_valid_o is a single-cycle pulse. IF holds req_i/pc_i stable until the pulse unless it asserts cancel_i.
- cancel_i:
  - In MISS: next state IDLE, busy_o=0, no inst_valid_o, no array write, even if a matching fill arrives the same cycle.
  - In IDLE: suppresses the pending hit pulse; no pulse next cycle.
- flush_i:
  - Highest synchronous priority. Clears all valid bits, state=IDLE, busy_o=0, inst_valid_o=0.
  - Overrides a simultaneous fill write and simultaneous cancel_i.
- rdy_in=0: all registers and arrays hold; inst_valid_o forced 0 that cycle.
  - A mem_pc_done_i pulse during rdy_in=0 is lost. The memory controller does not complete during rdy_in=0.
- Aliasing: two PCs with same index, different tag evict each other. The last fill wins.
- A fill always writes the full line (one word). No partial/byte handling.

Test Plan:
- Cold miss then hit:
  - After reset, req pc=0x1000. mem_pc_o=0x1000, busy_o=1.
  - Return pc_num=0x1000, inst=0x00500093. One cycle later inst_valid_o=1, inst_o=0x00500093.
  - Re-request 0x1000: inst_valid_o=1 the next cycle, mem_pc_done_i not required.
- Stale return filter:
  - In MISS on 0x1004, return pc_num=0x1000. No pulse, no array write.
  - Then return pc_num=0x1004, inst=0x13. Pulse with inst_pc_o=0x1004.
- Conflict eviction (INDEX_W=6):
  - Fill 0x0100, then fill 0x0200 (same index 0).
  - Request 0x0100 misses again, mem_pc_o=0x0100.
- IO uncached:
  - Request 0x30000. Fill forwards inst with a pulse.
  - Second request to 0x30000 misses again.
- Cancel/flush priority:
  - Matching fill arrives with cancel_i=1: no pulse, line stays invalid.
  - flush_i after filling 0x1000: subsequent request to 0x1000 misses.
- Async reset mid-MISS:
  - Drop rst low between clock edges. Outputs zero immediately.
  - After release, a previously filled PC misses.
